// File: rtl/seg7_scan_driver_if.sv
// Bundle between the text-output stage and the 7-segment scan driver.
//   iEnable      : run scanning (driven by the master)
//   iChar1..4    : active-low segment bytes for digits 0..3 (bit 7 = DP)
//   oSeg         : active-low shared segment bus (driven by the driver)
//   oAnode       : active-low one-hot anode enables, bit n = digit n
//   oFrame_done  : one-cycle pulse at the end of each complete frame
interface seg7_scan_driver_if;
  logic       iEnable;
  logic [7:0] iChar1;
  logic [7:0] iChar2;
  logic [7:0] iChar3;
  logic [7:0] iChar4;
  logic [7:0] oSeg;
  logic [3:0] oAnode;
  logic       oFrame_done;

  modport master (
    output iEnable, iChar1, iChar2, iChar3, iChar4,
    input  oSeg, oAnode, oFrame_done
  );

  modport slave (
    input  iEnable, iChar1, iChar2, iChar3, iChar4,
    output oSeg, oAnode, oFrame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
// Each digit slot is DIGIT_CYCLES long: (DIGIT_CYCLES-GUARD_CYCLES) cycles lit,
// then GUARD_CYCLES cycles with all anodes off to suppress ghosting. The four
// character bytes are snapshotted at frame start so the display never tears.
//   iClk    : system clock, rising edge
//   iReset  : synchronous active-high reset
//   bus     : slave side of seg7_scan_driver_if (enable, chars, seg/anode, frame pulse)
module seg7_scan_driver #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                iClk,
  input  logic                iReset,
  seg7_scan_driver_if.slave   bus
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] ON_LAST    = CW'(DIGIT_CYCLES - GUARD_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ON, GUARD} state_t;

  state_t          state_q, state_d;
  logic [1:0]      digit_q, digit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0][7:0] shadow_q, shadow_d;
  logic [7:0]      seg_q, seg_d;
  logic [3:0]      anode_q, anode_d;
  logic            frame_q, frame_d;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q  <= IDLE;
      digit_q  <= '0;
      cnt_q    <= '0;
      shadow_q <= '1;
      seg_q    <= '1;
      anode_q  <= '1;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      anode_q  <= anode_d;
      frame_q  <= frame_d;
    end
  end

  // Output registers are loaded from the next-state values so the lit digit
  // appears the cycle right after the transition edge, yet the pins are
  // still driven straight from flops.
  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    seg_d    = '1;
    anode_d  = '1;
    frame_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.iEnable) begin
          shadow_d = {bus.iChar4, bus.iChar3, bus.iChar2, bus.iChar1};
          digit_d  = '0;
          cnt_d    = '0;
          state_d  = ON;
        end
      end
      ON: begin
        if (cnt_q == ON_LAST) begin
          cnt_d   = '0;
          state_d = GUARD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          cnt_d = '0;
          if (digit_q != 2'd3) begin
            digit_d = digit_q + 2'd1;
            state_d = ON;
          end else if (bus.iEnable) begin
            shadow_d = {bus.iChar4, bus.iChar3, bus.iChar2, bus.iChar1};
            digit_d  = '0;
            state_d  = ON;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == ON) begin
      anode_d = ~(4'b0001 << digit_d);
      seg_d   = shadow_d[digit_d];
    end
    // Pulse during the final dark cycle of digit 3.
    frame_d = (state_d == GUARD) && (digit_d == 2'd3) && (cnt_d == GUARD_LAST);
  end

  assign bus.oSeg        = seg_q;
  assign bus.oAnode      = anode_q;
  assign bus.oFrame_done = frame_q;

endmodule
